// File: rtl/dmi_pkg.sv
// Shared definitions for the DMI bridge: op-status codes, FSM states, default widths.
package dmi_pkg;

  localparam int unsigned DMI_DATA_W = 32;

  localparam logic [1:0] DMI_OK   = 2'b00;
  localparam logic [1:0] DMI_FAIL = 2'b10;
  localparam logic [1:0] DMI_BUSY = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StHold = 2'b10
  } dmi_state_e;

endpackage

// File: rtl/dmi_sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous active-low reset.
module dmi_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dmi_core_to_jtag_rsp.sv
// Core-domain DMI response path: tracks one outstanding request, captures the response and
// hands it to the TCK side as a toggle with data/status held until the ack toggle returns.
module dmi_core_to_jtag_rsp
  import dmi_pkg::*;
#(
  parameter int unsigned DATA_W      = DMI_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              reg_en_i,
  input  logic              reg_wr_en_i,
  input  logic              core_rsp_valid_i,
  input  logic [DATA_W-1:0] core_rsp_rdata_i,
  input  logic              core_rsp_err_i,
  input  logic              dmireset_i,
  input  logic              jtag_ack_tgl_i,
  output logic              rsp_tgl_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [1:0]        rsp_status_o,
  output logic              busy_o
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYC);

  dmi_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic              tgl_q, tgl_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        status_q, status_d;
  logic              sticky_q, sticky_d;
  logic              ack_sync;

  dmi_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (jtag_ack_tgl_i),
    .q_o   (ack_sync)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    tgl_d    = tgl_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    sticky_d = sticky_q;

    unique case (state_q)
      StIdle: begin
        if (reg_en_i) begin
          state_d = StWait;
          is_wr_d = reg_wr_en_i;
          cnt_d   = '0;
        end
      end
      StWait: begin
        // A strobe on the timeout cycle takes priority over the forced failure.
        if (core_rsp_valid_i) begin
          rdata_d  = is_wr_q ? '0 : core_rsp_rdata_i;
          status_d = core_rsp_err_i ? DMI_FAIL : DMI_OK;
          tgl_d    = ~tgl_q;
          state_d  = StHold;
        end else if (cnt_q == CntLast) begin
          rdata_d  = '0;
          status_d = DMI_FAIL;
          tgl_d    = ~tgl_q;
          state_d  = StHold;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (ack_sync == tgl_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (dmireset_i) begin
      sticky_d = 1'b0;
    end else if (reg_en_i && (state_q != StIdle)) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_wr_q  <= 1'b0;
      tgl_q    <= 1'b0;
      rdata_q  <= '0;
      status_q <= DMI_OK;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      tgl_q    <= tgl_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      sticky_q <= sticky_d;
    end
  end

  assign rsp_tgl_o    = tgl_q;
  assign rsp_rdata_o  = rdata_q;
  assign rsp_status_o = sticky_q ? DMI_BUSY : status_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_dmi_core_to_jtag_rsp.sv
// Scoreboard bench for dmi_core_to_jtag_rsp: expected responses are queued when stimulus is
// driven and checked when rsp_tgl changes.
module tb_dmi_core_to_jtag_rsp;
  import dmi_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reg_en = 1'b0;
  logic          reg_wr_en = 1'b0;
  logic          core_rsp_valid = 1'b0;
  logic [DW-1:0] core_rsp_rdata = '0;
  logic          core_rsp_err = 1'b0;
  logic          dmireset = 1'b0;
  logic          jtag_ack_tgl = 1'b0;
  logic          rsp_tgl;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_status;
  logic          busy;

  dmi_core_to_jtag_rsp #(
    .DATA_W     (DW),
    .TIMEOUT_CYC(TO),
    .SYNC_STAGES(SS)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .reg_en_i        (reg_en),
    .reg_wr_en_i     (reg_wr_en),
    .core_rsp_valid_i(core_rsp_valid),
    .core_rsp_rdata_i(core_rsp_rdata),
    .core_rsp_err_i  (core_rsp_err),
    .dmireset_i      (dmireset),
    .jtag_ack_tgl_i  (jtag_ack_tgl),
    .rsp_tgl_o       (rsp_tgl),
    .rsp_rdata_o     (rsp_rdata),
    .rsp_status_o    (rsp_status),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [1:0]    status;
    int unsigned   cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic        exp_tgl = 1'b0;
  logic        prev_tgl = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Drive point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic [1:0] st, input int unsigned c);
    exp_t e;
    e.rdata  = d;
    e.status = st;
    e.cyc    = c;
    exp_q.push_back(e);
    exp_tgl = ~exp_tgl;
  endtask

  task automatic start_req(input logic wr);
    reg_en    = 1'b1;
    reg_wr_en = wr;
    tick();
    reg_en    = 1'b0;
    reg_wr_en = 1'b0;
    check("busy_after_req", busy, 1'b1);
  endtask

  task automatic strobe(input logic [DW-1:0] d, input logic err, input logic wr);
    push_exp(wr ? '0 : d, err ? DMI_FAIL : DMI_OK, cyc + 1);
    core_rsp_valid = 1'b1;
    core_rsp_rdata = d;
    core_rsp_err   = err;
    tick();
    core_rsp_valid = 1'b0;
    core_rsp_rdata = '0;
    core_rsp_err   = 1'b0;
  endtask

  // Return the ack; busy must drop exactly SYNC_STAGES+1 edges later.
  task automatic ack_and_release();
    jtag_ack_tgl = exp_tgl;
    repeat (SS) tick();
    check("busy_before_ack_sync", busy, 1'b1);
    tick();
    check("busy_after_ack_sync", busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_tgl = rsp_tgl;
    end else if (rsp_tgl !== prev_tgl) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tgl", rsp_tgl, prev_tgl);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_rdata", rsp_rdata, mon_e.rdata);
        check("sb_status", rsp_status, mon_e.status);
        check("sb_tgl_cycle", cyc, mon_e.cyc);
      end
      prev_tgl = rsp_tgl;
    end
  end

  initial begin
    repeat (2) tick();
    check("rst_tgl", rsp_tgl, 1'b0);
    check("rst_rdata", rsp_rdata, '0);
    check("rst_status", rsp_status, DMI_OK);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Read with strobe 5 cycles after the request.
    start_req(1'b0);
    repeat (4) tick();
    strobe(32'hDEAD_BEEF, 1'b0, 1'b0);
    repeat (3) tick();
    check("read_hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("read_hold_busy", busy, 1'b1);
    ack_and_release();

    // Write with error: data forced to zero.
    start_req(1'b1);
    repeat (2) tick();
    strobe(32'h1234_5678, 1'b1, 1'b1);
    tick();
    ack_and_release();

    // Timeout: toggle on the TO-th edge after entering WAIT.
    start_req(1'b0);
    push_exp('0, DMI_FAIL, cyc + TO);
    repeat (TO) tick();
    check("timeout_busy", busy, 1'b1);
    tick();
    ack_and_release();

    // Strobe on the timeout cycle wins.
    start_req(1'b0);
    repeat (TO - 1) tick();
    strobe(32'hA5A5_5A5A, 1'b0, 1'b0);
    tick();
    ack_and_release();

    // Sticky busy during HOLD, strobe ignored outside WAIT, dmireset clears.
    start_req(1'b0);
    strobe(32'h0000_0011, 1'b0, 1'b0);
    tick();
    reg_en = 1'b1;
    tick();
    reg_en = 1'b0;
    check("busy_sticky_status", rsp_status, DMI_BUSY);
    core_rsp_valid = 1'b1;
    core_rsp_rdata = 32'hFFFF_0000;
    core_rsp_err   = 1'b1;
    tick();
    core_rsp_valid = 1'b0;
    core_rsp_err   = 1'b0;
    check("hold_ignore_rdata", rsp_rdata, 32'h0000_0011);
    dmireset = 1'b1;
    tick();
    dmireset = 1'b0;
    check("dmireset_clears", rsp_status, DMI_OK);
    dmireset = 1'b1;
    reg_en   = 1'b1;
    tick();
    dmireset = 1'b0;
    reg_en   = 1'b0;
    check("dmireset_wins", rsp_status, DMI_OK);
    check("dmireset_no_abort", busy, 1'b1);
    ack_and_release();
    repeat (2) tick();
    check("dropped_req_idle", busy, 1'b0);

    // Reset mid-WAIT abandons the transaction.
    start_req(1'b0);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    #5;
    jtag_ack_tgl = 1'b0;
    exp_tgl      = 1'b0;
    rst_n        = 1'b1;
    check("midrst_tgl", rsp_tgl, 1'b0);
    check("midrst_rdata", rsp_rdata, '0);
    check("midrst_status", rsp_status, DMI_OK);
    check("midrst_busy", busy, 1'b0);
    tick();
    core_rsp_valid = 1'b1;
    core_rsp_rdata = 32'hCAFE_F00D;
    tick();
    core_rsp_valid = 1'b0;
    tick();
    check("post_rst_tgl", rsp_tgl, 1'b0);
    check("post_rst_busy", busy, 1'b0);

    repeat (3) tick();
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmi_core_to_jtag_rsp.md
Name: dmi_core_to_jtag_rsp

Overview:
Core-clock-domain return path of the DMI bridge. Takes the single-cycle read/write request pulses already synchronized into the core domain, tracks the outstanding transaction, and captures the core's response (read data and error). It presents that response to the JTAG (TCK) side as a toggle plus held-stable data and status. The response is released only after the JTAG side returns an acknowledge toggle, which this block synchronizes. Also provides timeout and sticky-busy reporting using DMI op-status semantics.

Parameters:
DATA_W, 32, width of DMI read data
TIMEOUT_CYC, 1023, core cycles allowed in WAIT before a forced failed response; legal range 1..65535
SYNC_STAGES, 2, flop stages on jtag_ack_tgl; minimum 2

Ports:
clk  input  1  core clock
rst_n  input  1  core reset, synchronous, active-low
reg_en  input  1  request pulse from the JTAG-to-core synchronizer (read or write)
reg_wr_en  input  1  qualifies reg_en as a write
core_rsp_valid  input  1  single-cycle response strobe from the debug module
core_rsp_rdata  input  DATA_W  read data; valid with core_rsp_valid
core_rsp_err  input  1  error flag; valid with core_rsp_valid
dmireset  input  1  single-cycle pulse, already in the clk domain; clears the sticky busy flag
jtag_ack_tgl  input  1  acknowledge toggle from the TCK domain (asynchronous)
rsp_tgl  output  1  toggles once per completed response
rsp_rdata  output  DATA_W  held response data
rsp_status  output  2  00 success, 10 failed, 11 busy (sticky)
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, timeout counter=0, rsp_tgl=0, rsp_rdata=0, rsp_status=00, busy=0, sticky_busy=0, all sync flops=0. Reset mid-transaction abandons it; no toggle is generated.
- FSM states: IDLE, WAIT, HOLD. Encoding lives in the package.
- IDLE: reg_en=1 -> WAIT. Latch is_wr=reg_wr_en. Clear the counter.
- WAIT, core_rsp_valid=1: next edge sets rsp_rdata = is_wr ? 0 : core_rsp_rdata. Set the status field to core_rsp_err ? 10 : 00, invert rsp_tgl, -> HOLD. Latency is exactly one clk from strobe to toggle.
- WAIT, no strobe: counter increments. When counter==TIMEOUT_CYC-1 and no strobe, next edge sets rsp_rdata=0, status=10, inverts rsp_tgl, -> HOLD.
- Strobe coinciding with the timeout cycle: the response wins, with normal capture.
- HOLD: rsp_rdata and rsp_status are frozen. Exit to IDLE on the first cycle where synchronized ack equals rsp_tgl. The IDLE transition takes effect on the following edge.
- The ack synchronizer is a SYNC_STAGES flop chain on jtag_ack_tgl. Comparison uses the last stage only.
- reg_en while state != IDLE: request dropped; sticky_busy set.
- core_rsp_valid outside WAIT: ignored; outputs unchanged.
- rsp_status output = sticky_busy ? 11 : captured status.
- dmireset clears sticky_busy on the next edge. It does not abort WAIT or HOLD.
- dmireset and a busy-causing reg_en in the same cycle: the clear wins, so sticky_busy=0.
- reg_en in IDLE with dmireset in the same cycle: the request is accepted normally.
- Counter width is clog2(TIMEOUT_CYC+1). It saturates and never wraps.
- Core-to-TCK data safety: rsp_rdata and rsp_status never change between a rsp_tgl edge and the matching ack. The only exception is the sticky_busy overlay, which the TCK side samples after seeing the toggle.

Decomposition:
- Shared header/package dmi_pkg holds:
  - status constants DMI_OK=2'b00, DMI_FAIL=2'b10, DMI_BUSY=2'b11
  - FSM state localparams
  - DATA_W default
- One natural sub-module: dmi_sync_bit, a parameterized SYNC_STAGES flop synchronizer with synchronous active-low reset. Instantiated for jtag_ack_tgl and reusable elsewhere in the DMI bridge.

Test Plan:
- Read: reg_en=1, reg_wr_en=0. core_rsp_valid with rdata=32'hDEADBEEF, err=0, 5 cycles later -> rsp_tgl 0->1 one cycle after the strobe; rsp_rdata=DEADBEEF; rsp_status=00; busy=1 until ack toggled to 1, plus SYNC_STAGES+1 cycles.
- Write with error: reg_en=1, reg_wr_en=1; strobe with err=1, rdata=32'h12345678 -> rsp_rdata=0, rsp_status=10, rsp_tgl inverts.
- Timeout (TIMEOUT_CYC=8): reg_en, no strobe -> toggle on the 8th edge after entering WAIT; status=10; rdata=0. Strobe exactly on the timeout cycle -> captured response, status 00.
- Busy: second reg_en during HOLD -> rsp_status=11 and the request is dropped. dmireset pulse -> status returns to the held value. dmireset and reg_en in the same cycle -> status not 11.
- Reset mid-WAIT: assert rst_n=0 for 1 cycle during WAIT -> all outputs 0, state IDLE. A later core_rsp_valid is ignored and rsp_tgl stays 0.
